key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Sits directly downstream of the key debounce stage.
- Consumes the debounced, active-low key level and classifies each gesture into single-cycle event pulses: short press, double click, long press and auto-repeat while held.
- Outputs feed the UI/control FSMs that need discrete key events instead of a raw level.
- Single clock domain; the input is already synchronous and glitch-free.

Parameters:
LONG_TIME, 50_000_000, cycles a first press must be held before long_press fires (1 s at 50 MHz); must be >= 2
REPEAT_TIME, 10_000_000, cycles between repeat_press pulses once in long-hold; must be >= 2
DCLICK_GAP, 15_000_000, cycles after a short release in which a second press counts as a double click; must be >= 2
WIDTH, $clog2(max(LONG_TIME,REPEAT_TIME,DCLICK_GAP)+1), shared counter width

Ports:
clk  input  1  system clock
rst  input  1  reset: one clock; reset is asynchronous and active-high
deb_key_n  input  1  debounced key level, 0 = pressed
short_press  output  1  one-cycle pulse: single press-release with no second press within DCLICK_GAP
double_click  output  1  one-cycle pulse: second press edge within DCLICK_GAP of a short release
long_press  output  1  one-cycle pulse: first press held LONG_TIME cycles
repeat_press  output  1  one-cycle pulse every REPEAT_TIME cycles while held after long_press
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, key_r=1.
  - All outputs 0.
- Edge detection:
  - key_r <= deb_key_n every cycle.
  - press_edge = key_r & ~deb_key_n.
  - release = deb_key_n (level).
- Outputs: all outputs are registered. Each event pulse is high for exactly one cycle, in the cycle after the deciding clock edge.
- Single counter cnt[WIDTH-1:0]:
  - Cleared on every state transition.
  - Increments by 1 otherwise while in PRESS1, LONG or WAIT2.
  - Held at 0 in IDLE and PRESS2.
  - Never wraps: each terminal compare forces a transition or a clear.
- FSM, evaluated on each rising clk edge:
  - IDLE: press_edge -> PRESS1.
  - PRESS1:
    - release -> WAIT2.
    - else cnt==LONG_TIME-1 -> LONG, pulse long_press.
  - LONG:
    - release -> IDLE, no pulse.
    - else cnt==REPEAT_TIME-1 -> pulse repeat_press, cnt<=0, stay in LONG.
  - WAIT2:
    - press_edge -> PRESS2, pulse double_click.
    - else cnt==DCLICK_GAP-1 -> IDLE, pulse short_press.
  - PRESS2:
    - release -> IDLE.
    - Hold duration is ignored; no long or repeat events.
- Latencies, counted from the edge at which press_edge is first sampled (E0):
  - long_press is high in the cycle after E(LONG_TIME).
  - repeat_press follows every REPEAT_TIME cycles after that.
- Simultaneous events:
  - PRESS1: release and the terminal count on the same edge -> release wins (WAIT2, no long_press).
  - WAIT2: press_edge and timeout on the same edge -> press wins (double_click, no short_press).
- At most one event pulse is high in any cycle.
- A gesture yields exactly one of short_press, double_click or long_press. repeat_press occurs only after long_press.
- Reset mid-operation:
  - Any state returns to IDLE and outputs clear immediately (async).
  - key_r resets to 1, so a key still held when rst deasserts is taken as a new press_edge on the first clock edge after release of reset.

Test Plan:
Params LONG_TIME=20, REPEAT_TIME=5, DCLICK_GAP=8 for all scenarios; E0 = first edge sampling deb_key_n=0.
- Short press: hold 3 cycles, release (sampled at edge R0), stay released -> short_press single pulse after edge R0+8; no other pulses; busy returns low with it.
- Double click: hold 3, release 4 cycles, press again, hold 6, release -> double_click pulse after the second press edge; short_press never asserted; busy low one cycle after final release sampled.
- Long/repeat: hold 37 cycles -> long_press after E20; repeat_press after E25, E30, E35; release -> IDLE with no further pulses.
- Boundaries:
  - Release sampled exactly at E20 -> no long_press; short_press 8 cycles later.
  - Second press edge exactly at WAIT2 edge R0+8 -> double_click, no short_press.
- Reset mid-LONG: assert rst asynchronously at E22 (key held) -> outputs and busy drop at once; deassert with key still held -> treated as new press; long_press 20 cycles after the first post-reset edge.
- Press held in PRESS2 for 40 cycles -> no long_press or repeat_press; only the earlier double_click.

Source files
------------

// File: rtl/key_event_decoder_if.sv
// Key event bundle: debounced key level in, classified event pulses and busy out.
interface key_event_decoder_if;
   logic deb_key_n;
   logic short_press;
   logic double_click;
   logic long_press;
   logic repeat_press;
   logic busy;

   modport master (
      output deb_key_n,
      input  short_press, double_click, long_press, repeat_press, busy
   );

   modport slave (
      input  deb_key_n,
      output short_press, double_click, long_press, repeat_press, busy
   );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies a debounced active-low key into short, double-click, long and repeat pulses.
//
// state  | meaning
// IDLE   | key released, waiting for a press edge
// PRESS1 | first press held, timing toward long_press
// LONG   | long hold reached, timing repeat_press intervals
// WAIT2  | short release seen, waiting for a second press
// PRESS2 | second press of a double click held, waiting for release
module key_event_decoder #(
   parameter int LONG_TIME   = 50_000_000,
   parameter int REPEAT_TIME = 10_000_000,
   parameter int DCLICK_GAP  = 15_000_000,
   parameter int WIDTH = $clog2(((LONG_TIME > REPEAT_TIME ? LONG_TIME : REPEAT_TIME) > DCLICK_GAP
                                 ? (LONG_TIME > REPEAT_TIME ? LONG_TIME : REPEAT_TIME)
                                 : DCLICK_GAP) + 1)
) (
   input logic                clk,
   input logic                rst,
   key_event_decoder_if.slave kif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      LONG   = 3'd2,
      WAIT2  = 3'd3,
      PRESS2 = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   cnt, cnt_nxt;
   logic               key_r;
   logic               short_q, dclick_q, long_q, repeat_q;
   logic               short_nxt, dclick_nxt, long_nxt, repeat_nxt;
   logic               press_edge;
   logic               release_lvl;

   assign press_edge  = key_r & ~kif.deb_key_n;
   assign release_lvl = kif.deb_key_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         key_r    <= 1'b1;
         short_q  <= 1'b0;
         dclick_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         key_r    <= kif.deb_key_n;
         short_q  <= short_nxt;
         dclick_q <= dclick_nxt;
         long_q   <= long_nxt;
         repeat_q <= repeat_nxt;
      end
   end

   // Release and press edges take priority over terminal counts on the same edge.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = '0;
      short_nxt  = 1'b0;
      dclick_nxt = 1'b0;
      long_nxt   = 1'b0;
      repeat_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (press_edge) state_nxt = PRESS1;
         end
         PRESS1: begin
            if (release_lvl) begin
               state_nxt = WAIT2;
            end else if (cnt == WIDTH'(LONG_TIME - 1)) begin
               state_nxt = LONG;
               long_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         LONG: begin
            if (release_lvl) begin
               state_nxt = IDLE;
            end else if (cnt == WIDTH'(REPEAT_TIME - 1)) begin
               repeat_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT2: begin
            if (press_edge) begin
               state_nxt  = PRESS2;
               dclick_nxt = 1'b1;
            end else if (cnt == WIDTH'(DCLICK_GAP - 1)) begin
               state_nxt = IDLE;
               short_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PRESS2: begin
            if (release_lvl) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign kif.short_press  = short_q;
   assign kif.double_click = dclick_q;
   assign kif.long_press   = long_q;
   assign kif.repeat_press = repeat_q;
   assign kif.busy         = (state != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: gesture-level reference model over directed and random key waveforms.
module tb_key_event_decoder;
   localparam int L    = 20;
   localparam int R    = 5;
   localparam int D    = 8;
   localparam int MAXN = 3000;

   localparam logic [4:0] EV_SHORT = 5'b10000;
   localparam logic [4:0] EV_DBL   = 5'b01000;
   localparam logic [4:0] EV_LONG  = 5'b00100;
   localparam logic [4:0] EV_REP   = 5'b00010;
   localparam logic [4:0] EV_BUSY  = 5'b00001;

   logic clk = 1'b0;
   logic rst;

   key_event_decoder_if kif ();

   key_event_decoder #(
      .LONG_TIME  (L),
      .REPEAT_TIME(R),
      .DCLICK_GAP (D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kif(kif)
   );

   always #5 clk = ~clk;

   bit         lvl   [MAXN];
   logic [4:0] exp_o [MAXN];
   int         n      = 0;
   int         checks = 0;
   int         errors = 0;

   function automatic logic [4:0] observed();
      return {kif.short_press, kif.double_click, kif.long_press, kif.repeat_press, kif.busy};
   endfunction

   task automatic check(input string tag, input int idx, input logic [4:0] obs, input logic [4:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%b expected=%b (short,dbl,long,rep,busy)", tag, idx, obs, expv);
      end
   endtask

   task automatic add(input bit v, input int count);
      for (int k = 0; k < count; k++) begin
         if (n < MAXN) begin
            lvl[n] = v;
            n++;
         end
      end
   endtask

   task automatic mark(input int t, input logic [4:0] ev);
      if (t < n) exp_o[t] = exp_o[t] | ev;
   endtask

   // Walks the key waveform gesture by gesture and places each expected event by arithmetic.
   task automatic build_model();
      int j, p, r, q, s, endg;
      bit prev;
      for (int i = 0; i < n; i++) exp_o[i] = '0;
      j = 0;
      while (j < n) begin
         prev = (j == 0) ? 1'b1 : lvl[j-1];
         if (!(lvl[j] == 1'b0 && prev == 1'b1)) begin
            j++;
            continue;
         end
         p = j;
         r = p + 1;
         while (r < n && lvl[r] == 1'b0) r++;
         if (r > p + L) begin
            mark(p + L, EV_LONG);
            for (int t = p + L + R; t < r; t += R) mark(t, EV_REP);
            endg = r;
         end else begin
            q = r + 1;
            while (q < n && q <= r + D && lvl[q] == 1'b1) q++;
            if (q < n && q <= r + D) begin
               mark(q, EV_DBL);
               s = q + 1;
               while (s < n && lvl[s] == 1'b0) s++;
               endg = s;
            end else begin
               mark(r + D, EV_SHORT);
               endg = r + D;
            end
         end
         for (int k = p; k < endg && k < n; k++) exp_o[k] = exp_o[k] | EV_BUSY;
         j = endg + 1;
      end
   endtask

   initial begin
      rst           = 1'b1;
      kif.deb_key_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("reset_state", 0, observed(), 5'b00000);
      @(negedge clk) rst = 1'b0;

      // directed gestures
      add(0, 3);  add(1, 15);                           // short press
      add(0, 3);  add(1, 4);  add(0, 6);  add(1, 15);   // double click
      add(0, 37); add(1, 15);                           // long + repeats
      add(0, 20); add(1, 15);                           // release exactly at terminal count
      add(0, 3);  add(1, 8);  add(0, 4);  add(1, 15);   // second press on the timeout edge
      add(0, 3);  add(1, 2);  add(0, 40); add(1, 15);   // long hold inside double click
      // random gestures
      for (int g = 0; g < 40; g++) begin
         add(0, int'($urandom_range(45, 1)));
         add(1, int'($urandom_range(14, 1)));
      end
      add(1, 15);

      build_model();

      for (int i = 0; i < n; i++) begin
         @(negedge clk) kif.deb_key_n = lvl[i];
         @(posedge clk);
         #1 check("seq", i, observed(), exp_o[i]);
      end

      // reset in the middle of a long hold
      @(negedge clk) kif.deb_key_n = 1'b0;
      for (int k = 0; k <= 22; k++) begin
         @(posedge clk);
         #1 check("pre_rst", k, observed(), (k == L) ? (EV_LONG | EV_BUSY) : EV_BUSY);
      end
      #2 rst = 1'b1;
      #1 check("async_rst", 0, observed(), 5'b00000);
      @(posedge clk);
      #1 check("rst_hold", 0, observed(), 5'b00000);
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k <= L + 1; k++) begin
         @(posedge clk);
         #1 check("post_rst", k, observed(), (k == L) ? (EV_LONG | EV_BUSY) : EV_BUSY);
      end
      @(negedge clk) kif.deb_key_n = 1'b1;
      @(posedge clk);
      #1 check("post_rst_release", 0, observed(), 5'b00000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
